// File: rtl/uart_pkg.sv
// uart_pkg: FCR field positions, 16-deep RX trigger levels and RX timeout FSM states.
package uart_pkg;
   localparam int FCR_EN   = 0;
   localparam int FCR_RXR  = 1;
   localparam int FCR_TXR  = 2;
   localparam int FCR_DMA  = 3;
   localparam int FCR_TRIG = 6;
   localparam int unsigned TRIG_LVL0 = 1;
   localparam int unsigned TRIG_LVL1 = 4;
   localparam int unsigned TRIG_LVL2 = 8;
   localparam int unsigned TRIG_LVL3 = 14;
   typedef enum logic [1:0] {
      TO_IDLE    = 2'd0,
      TO_COUNT   = 2'd1,
      TO_EXPIRED = 2'd2
   } to_state_e;
   function automatic int unsigned trig_level(input logic [1:0] sel);
      return sel == 2'd0 ? TRIG_LVL0 : sel == 2'd1 ? TRIG_LVL1 : sel == 2'd2 ? TRIG_LVL2 : TRIG_LVL3;
   endfunction
endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout: character-timeout FSM; flags a non-empty RX FIFO left untouched
// for four character times of bit ticks.
module uart_rx_timeout
   import uart_pkg::*;
#(
   parameter int TO_W = 6
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic       clear,
   input  logic       empty,
   input  logic       bit_tick,
   input  logic [3:0] char_bits,
   output logic       rx_timeout
);
   to_state_e        state_q, state_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;
   logic [TO_W-1:0]  thr;
   assign thr = TO_W'({char_bits, 2'b00});
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en || empty) begin
         state_d = TO_IDLE;
         cnt_d   = '0;
      end else if (state_q == TO_IDLE || clear) begin
         state_d = TO_COUNT;
         cnt_d   = '0;
      end else if (state_q == TO_COUNT && cnt_q >= thr) begin
         state_d = TO_EXPIRED;
         cnt_d   = '0;
      end else if (state_q == TO_COUNT && bit_tick) begin
         cnt_d   = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= TO_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // en already folds in the RX reset pulse, so expiry drops in the pulse cycle
   assign rx_timeout = (state_q == TO_EXPIRED) && en;
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: FCR decode, RX/TX FIFO reset pulses, RX pop gating, trigger and
// character-timeout indications for the UART FIFOs.
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 5,
   parameter int TO_W  = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             fcr_we,
   input  logic [7:0]       fcr_data,
   input  logic             rbr_rd,
   input  logic             rx_push,
   input  logic             bit_tick,
   input  logic [3:0]       char_bits,
   input  logic [CNT_W-1:0] rx_fifo_cnt,
   input  logic             rx_empty,
   output logic             rx_fifo_read,
   output logic             rx_fifo_rstn,
   output logic             tx_fifo_rstn,
   output logic             fifo_en,
   output logic             dma_mode,
   output logic             rx_trig,
   output logic             rx_timeout
);
   logic             fifo_en_q, fifo_en_d;
   logic             dma_q, dma_d;
   logic [1:0]       sel_q, sel_d;
   logic             rx_rst_q, rx_rst_d;
   logic             tx_rst_q, tx_rst_d;
   logic             trig_q, trig_d;
   logic             en_chg;
   logic [CNT_W-1:0] trig_lvl;
   // trigger table is defined for 16 entries; scale it for other depths
   assign trig_lvl = CNT_W'(trig_level(sel_q) * DEPTH / 16);
   always_comb begin
      en_chg    = fcr_data[FCR_EN] != fifo_en_q;
      fifo_en_d = fcr_we ? fcr_data[FCR_EN] : fifo_en_q;
      dma_d     = fcr_we ? fcr_data[FCR_DMA] : dma_q;
      sel_d     = (fcr_we && fcr_data[FCR_EN]) ? fcr_data[FCR_TRIG +: 2] : sel_q;
      rx_rst_d  = fcr_we && (fcr_data[FCR_RXR] || en_chg);
      tx_rst_d  = fcr_we && (fcr_data[FCR_TXR] || en_chg);
      trig_d    = fifo_en_q ? (rx_fifo_cnt >= trig_lvl) : !rx_empty;
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fifo_en_q <= 1'b0;
         dma_q     <= 1'b0;
         sel_q     <= 2'b00;
         rx_rst_q  <= 1'b0;
         tx_rst_q  <= 1'b0;
         trig_q    <= 1'b0;
      end else begin
         fifo_en_q <= fifo_en_d;
         dma_q     <= dma_d;
         sel_q     <= sel_d;
         rx_rst_q  <= rx_rst_d;
         tx_rst_q  <= tx_rst_d;
         trig_q    <= trig_d;
      end
   end
   assign fifo_en      = fifo_en_q;
   assign dma_mode     = dma_q;
   assign rx_fifo_rstn = !rx_rst_q;
   assign tx_fifo_rstn = !tx_rst_q;
   assign rx_trig      = trig_q;
   assign rx_fifo_read = rbr_rd && !rx_empty && rx_fifo_rstn;
   uart_rx_timeout #(.TO_W(TO_W)) u_timeout (
      .clk        (clk),
      .rstn       (rstn),
      .en         (fifo_en_q && rx_fifo_rstn),
      .clear      (rx_push || rx_fifo_read),
      .empty      (rx_empty),
      .bit_tick   (bit_tick),
      .char_bits  (char_bits),
      .rx_timeout (rx_timeout)
   );
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed table, corner sequences and randomized traffic checked
// against a behavioural model of the FIFO control rules.
module tb_uart_fifo_ctrl;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       fcr_we = 1'b0;
   logic [7:0] fcr_data = 8'h00;
   logic       rbr_rd = 1'b0;
   logic       rx_push = 1'b0;
   logic       bit_tick = 1'b0;
   logic [3:0] char_bits = 4'd10;
   logic [4:0] rx_fifo_cnt = 5'd0;
   logic       rx_empty = 1'b1;
   logic       rx_fifo_read, rx_fifo_rstn, tx_fifo_rstn, fifo_en, dma_mode, rx_trig, rx_timeout;
   int n_cmp = 0;
   int n_bad = 0;
   // model state
   bit       m_en, m_dma, m_rxp, m_txp, m_trig, m_watch, m_exp;
   bit [1:0] m_sel;
   int       m_quiet;
   uart_fifo_ctrl dut (
      .clk          (clk),
      .rstn         (rstn),
      .fcr_we       (fcr_we),
      .fcr_data     (fcr_data),
      .rbr_rd       (rbr_rd),
      .rx_push      (rx_push),
      .bit_tick     (bit_tick),
      .char_bits    (char_bits),
      .rx_fifo_cnt  (rx_fifo_cnt),
      .rx_empty     (rx_empty),
      .rx_fifo_read (rx_fifo_read),
      .rx_fifo_rstn (rx_fifo_rstn),
      .tx_fifo_rstn (tx_fifo_rstn),
      .fifo_en      (fifo_en),
      .dma_mode     (dma_mode),
      .rx_trig      (rx_trig),
      .rx_timeout   (rx_timeout)
   );
   always #5 clk = ~clk;
   function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction
   function automatic int lvl(bit [1:0] s);
      case (s)
         2'd0: return 1;
         2'd1: return 4;
         2'd2: return 8;
         default: return 14;
      endcase
   endfunction
   function automatic void model_reset();
      {m_en, m_dma, m_rxp, m_txp, m_trig, m_watch, m_exp} = '0;
      m_sel   = 2'b00;
      m_quiet = 0;
   endfunction
   function automatic void check_all();
      chk("fifo_en", 8'(fifo_en), 8'(m_en));
      chk("dma_mode", 8'(dma_mode), 8'(m_dma));
      chk("rx_fifo_rstn", 8'(rx_fifo_rstn), 8'(!m_rxp));
      chk("tx_fifo_rstn", 8'(tx_fifo_rstn), 8'(!m_txp));
      chk("rx_fifo_read", 8'(rx_fifo_read), 8'(rbr_rd && !rx_empty && !m_rxp));
      chk("rx_trig", 8'(rx_trig), 8'(m_trig));
      chk("rx_timeout", 8'(rx_timeout), 8'(m_exp && m_en && !m_rxp));
   endfunction
   // quiet = bit ticks seen since the FIFO last became non-empty or was touched
   function automatic void model_update();
      bit rd  = rbr_rd && !rx_empty && !m_rxp;
      bit clr = rx_push || rd;
      int thr = 4 * int'(char_bits);
      if (!m_en || m_rxp || rx_empty) begin
         m_watch = 0; m_quiet = 0; m_exp = 0;
      end else if (!m_watch || clr) begin
         m_watch = 1; m_quiet = 0; m_exp = 0;
      end else begin
         m_exp = m_exp || (m_quiet >= thr);
         if (bit_tick) m_quiet++;
      end
      m_trig = m_en ? (int'(rx_fifo_cnt) >= lvl(m_sel)) : !rx_empty;
      if (fcr_we) begin
         m_rxp = fcr_data[1] || (fcr_data[0] != m_en);
         m_txp = fcr_data[2] || (fcr_data[0] != m_en);
         m_en  = fcr_data[0];
         m_dma = fcr_data[3];
         if (fcr_data[0]) m_sel = fcr_data[7:6];
      end else begin
         m_rxp = 0;
         m_txp = 0;
      end
   endfunction
   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask
   task automatic run_ticks(int n, bit last_hi);
      for (int t = 1; t <= n; t++) begin
         bit_tick = 1'b1;
         step();
         bit_tick = 1'b0;
         step();
         chk("timeout_tick", 8'(rx_timeout), 8'(last_hi && t == n));
      end
   endtask
   typedef struct {
      logic       we;
      logic [7:0] d;
      logic       rd;
      logic       emp;
      logic [4:0] cnt;
      logic [5:0] ex;
   } row_t;
   row_t tbl[17];
   initial begin
      // expected {fifo_en, dma_mode, rx_fifo_rstn, tx_fifo_rstn, rx_fifo_read, rx_trig}
      tbl[0]  = '{1'b1, 8'hC1, 1'b0, 1'b1, 5'd0,  6'b001100};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0,  6'b100000};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1,  6'b101100};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd14, 6'b101100};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd14, 6'b101111};
      tbl[5]  = '{1'b1, 8'h08, 1'b1, 1'b0, 5'd13, 6'b101111};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd13, 6'b010000};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd13, 6'b011101};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  6'b011101};
      tbl[9]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 5'd0,  6'b011100};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  6'b010100};
      tbl[11] = '{1'b1, 8'h04, 1'b0, 1'b1, 5'd0,  6'b011100};
      tbl[12] = '{1'b1, 8'h04, 1'b0, 1'b1, 5'd0,  6'b001000};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  6'b001000};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  6'b001100};
      tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0,  6'b001100};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd3,  6'b001110};
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      for (int i = 0; i < 17; i++) begin
         fcr_we = tbl[i].we; fcr_data = tbl[i].d; rbr_rd = tbl[i].rd;
         rx_empty = tbl[i].emp; rx_fifo_cnt = tbl[i].cnt;
         @(negedge clk);
         check_all();
         chk($sformatf("table_row%0d", i), 8'({fifo_en, dma_mode, rx_fifo_rstn, tx_fifo_rstn, rx_fifo_read, rx_trig}), 8'(tbl[i].ex));
         @(posedge clk);
         model_update();
         #1;
      end
      fcr_we = 1'b0; rbr_rd = 1'b0;
      // enable FIFO with trigger 14
      rx_empty = 1'b1; rx_fifo_cnt = 5'd0; fcr_we = 1'b1; fcr_data = 8'hC1;
      step();
      fcr_we = 1'b0;
      chk("enable_rx_pulse", 8'(rx_fifo_rstn), 8'd0);
      chk("enable_tx_pulse", 8'(tx_fifo_rstn), 8'd0);
      chk("enable_fifo_en", 8'(fifo_en), 8'd1);
      step();
      chk("pulse_width_rx", 8'(rx_fifo_rstn), 8'd1);
      chk("pulse_width_tx", 8'(tx_fifo_rstn), 8'd1);
      rx_empty = 1'b0; rx_fifo_cnt = 5'd13;
      step();
      chk("trig14_below", 8'(rx_trig), 8'd0);
      rx_fifo_cnt = 5'd14;
      step();
      chk("trig14_at", 8'(rx_trig), 8'd1);
      // trigger 8 with pushes; count lags push by one cycle
      fcr_we = 1'b1; fcr_data = 8'h81; rx_empty = 1'b1; rx_fifo_cnt = 5'd0;
      step();
      fcr_we = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         rx_push = 1'b1;
         step();
         rx_push = 1'b0; rx_empty = 1'b0; rx_fifo_cnt = 5'(i);
         step();
         chk($sformatf("trig8_push%0d", i), 8'(rx_trig), 8'(i >= 8));
      end
      rbr_rd = 1'b1;
      step();
      rbr_rd = 1'b0; rx_fifo_cnt = 5'd7;
      step();
      chk("trig8_after_read", 8'(rx_trig), 8'd0);
      // character timeout, char_bits = 10
      char_bits = 4'd10; rx_fifo_cnt = 5'd1; rx_push = 1'b1;
      step();
      rx_push = 1'b0;
      run_ticks(40, 1'b1);
      rbr_rd = 1'b1;
      step();
      rbr_rd = 1'b0;
      chk("timeout_clear_read", 8'(rx_timeout), 8'd0);
      run_ticks(39, 1'b0);
      rx_push = 1'b1;
      step();
      rx_push = 1'b0;
      run_ticks(40, 1'b1);
      // RX reset while expired
      fcr_we = 1'b1; fcr_data = 8'h03;
      step();
      fcr_we = 1'b0;
      chk("exp_reset_rx_pulse", 8'(rx_fifo_rstn), 8'd0);
      chk("exp_reset_no_tx", 8'(tx_fifo_rstn), 8'd1);
      chk("exp_reset_timeout", 8'(rx_timeout), 8'd0);
      rx_empty = 1'b1; rx_fifo_cnt = 5'd0;
      step();
      chk("exp_reset_idle", 8'(rx_timeout), 8'd0);
      // read gating and FIFO-disabled behaviour
      rbr_rd = 1'b1;
      #3 chk("read_gate_empty", 8'(rx_fifo_read), 8'd0);
      step();
      rbr_rd = 1'b0; fcr_we = 1'b1; fcr_data = 8'h00;
      step();
      fcr_we = 1'b0;
      step();
      rx_empty = 1'b0; rx_fifo_cnt = 5'd5;
      step();
      chk("disabled_trig_nonempty", 8'(rx_trig), 8'd1);
      run_ticks(50, 1'b0);
      rx_empty = 1'b1; rx_fifo_cnt = 5'd0;
      step();
      chk("disabled_trig_empty", 8'(rx_trig), 8'd0);
      // asynchronous reset mid-count
      fcr_we = 1'b1; fcr_data = 8'h09;
      step();
      fcr_we = 1'b0;
      step();
      rx_empty = 1'b0; rx_fifo_cnt = 5'd2;
      step();
      run_ticks(10, 1'b0);
      #2 rstn = 1'b0;
      #1;
      chk("areset_outputs", 8'({fifo_en, dma_mode, rx_fifo_rstn, tx_fifo_rstn, rx_trig, rx_timeout}), 8'b001100);
      model_reset();
      @(posedge clk);
      #1 rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("release_no_pulse", 8'({rx_fifo_rstn, tx_fifo_rstn}), 8'b11);
      end
      // randomized traffic; odd blocks are quiet so timeouts can mature
      for (int b = 0; b < 20; b++) begin
         char_bits = 4'($urandom_range(7, 12));
         for (int i = 0; i < 200; i++) begin
            fcr_we   = $urandom_range(0, (b % 2 != 0) ? 299 : 59) == 0;
            fcr_data = 8'($urandom);
            if ($urandom_range(0, 3) != 0) fcr_data[0] = 1'b1;
            rbr_rd   = $urandom_range(0, (b % 2 != 0) ? 399 : 8) == 0;
            rx_push  = $urandom_range(0, (b % 2 != 0) ? 399 : 8) == 0;
            bit_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) rx_fifo_cnt = 5'($urandom_range(0, 16));
            rx_empty = rx_fifo_cnt == 5'd0;
            step();
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
